// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel engine.
// Latency: none (types, constants and a combinational clamp function only).
// Backpressure: none; consumers are free-running pipelines.
package sobel_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } sobel_state_t;

  // Sobel taps: outer rows/columns weigh 1, the centre row/column weighs 2.
  localparam int KW_SIDE   = 1;
  localparam int KW_CENTRE = 2;

  // Working width of the clamp helper; wide enough for any sane PIX_W.
  localparam int CLAMP_W = 16;

  // Saturate a signed raw gradient into an unsigned pix_w-bit pixel range.
  function automatic logic [CLAMP_W-1:0] clamp_pix(input logic signed [CLAMP_W-1:0] raw,
                                                   input int pix_w);
    logic signed [CLAMP_W-1:0] max_v;
    max_v = CLAMP_W'((1 << pix_w) - 1);
    if (raw < 0)
      return '0;
    else if (raw > max_v)
      return $unsigned(max_v);
    else
      return $unsigned(raw);
  endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// One-line delay for the Sobel window: output is the sample written DEPTH advances ago.
// Latency: DEPTH enabled cycles; read is combinational from the slot about to be overwritten.
// Backpressure: none; i_en simply freezes the line.
module sobel_linebuf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;

  assign o_dout = r_mem[r_ptr];

  // Overwrite the oldest sample with the newest one on each advance.
  always_ff @(posedge clk) begin
    if (i_en)
      r_mem[r_ptr] <= i_din;
  end

  // Circular pointer over the DEPTH slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ptr <= '0;
    else if (i_en)
      r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel: reads a frame in raster order, emits clamped gx/gy (and mag with SOBEL_MAG_EN).
// Latency: result p is valid 2 cycles after the read strobe of pixel p+IMG_W+1; 1 pixel/cycle.
// Backpressure: none; frame memory must answer every cycle and the result sink must always accept.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int PIX_W  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [PIX_W-1:0]  gx,
`ifdef SOBEL_MAG_EN
  output logic [PIX_W-1:0]  mag,
`endif
  output logic [PIX_W-1:0]  gy
);

  localparam int N   = IMG_W * IMG_H;
  localparam int RW  = PIX_W + 4;
  localparam int QW  = $clog2(N + IMG_W + 2);
  localparam int CW  = $clog2(IMG_W);
  localparam int RRW = $clog2(IMG_H);
  localparam logic signed [RW-1:0] K_S = RW'(KW_SIDE);
  localparam logic signed [RW-1:0] K_C = RW'(KW_CENTRE);

  sobel_state_t r_state, w_next;

  logic [ADDR_W-1:0] r_rd_addr, r_res_addr;
  logic [QW-1:0]     r_slot, r_flush;
  logic [CW-1:0]     r_col;
  logic [RRW-1:0]    r_row;
  logic              r_in_vld, r_in_zero;
  logic              w_start, w_flush_slot, w_adv, w_emit, w_border, w_last_out;
  logic [PIX_W-1:0]  w_pix, w_lb_mid, w_lb_top;
  logic [PIX_W-1:0]  r_c1_t, r_c1_m, r_c1_b, r_c2_t, r_c2_m, r_c2_b;
  logic signed [RW-1:0] w_gx_raw, w_gy_raw;

  function automatic logic signed [RW-1:0] sx(input logic [PIX_W-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next state and control strobes; start is only honoured in IDLE.
  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    w_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next  = S_READ;
          w_start = 1'b1;
        end
      end
      S_READ: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (r_rd_addr == ADDR_W'(N - 1))
          w_next = S_FLUSH;
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (w_last_out)
          w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign rd_addr      = r_rd_addr;
  assign w_last_out   = out_valid && (out_addr == ADDR_W'(N - 1));
  // IMG_W+1 zero slots push the last real pixel far enough to centre the final result.
  assign w_flush_slot = (r_state == S_FLUSH) && (r_flush < QW'(IMG_W + 1));
  assign w_adv        = r_in_vld;
  assign w_pix        = r_in_zero ? '0 : rd_data;
  // Slot q completes the neighbourhood of result q-IMG_W-1.
  assign w_emit       = w_adv && (r_slot >= QW'(IMG_W + 1));
  assign w_border     = (r_row == '0) || (r_row == RRW'(IMG_H - 1)) ||
                        (r_col == '0) || (r_col == CW'(IMG_W - 1));

  // Read/flush/result counters and the one-cycle memory-latency alignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_vld   <= 1'b0;
      r_in_zero  <= 1'b0;
      r_rd_addr  <= '0;
      r_flush    <= '0;
      r_slot     <= '0;
      r_res_addr <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      r_in_vld  <= rd_en || w_flush_slot;
      r_in_zero <= w_flush_slot;
      if (w_start) begin
        r_rd_addr  <= '0;
        r_flush    <= '0;
        r_slot     <= '0;
        r_res_addr <= '0;
        r_col      <= '0;
        r_row      <= '0;
      end else begin
        if (rd_en)        r_rd_addr <= r_rd_addr + ADDR_W'(1);
        if (w_flush_slot) r_flush   <= r_flush + QW'(1);
        if (w_adv)        r_slot    <= r_slot + QW'(1);
        if (w_emit) begin
          r_res_addr <= r_res_addr + ADDR_W'(1);
          if (r_col == CW'(IMG_W - 1)) begin
            r_col <= '0;
            r_row <= r_row + RRW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
      end
    end
  end

  // Row r-1 feeds from row r, forming the two-line history.
  sobel_linebuf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_mid (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_adv),
    .i_din  (w_pix),
    .o_dout (w_lb_mid)
  );

  sobel_linebuf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_top (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_adv),
    .i_din  (w_lb_mid),
    .o_dout (w_lb_top)
  );

  // Two registered window columns; the right column is the live line-buffer/memory output.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_c1_t <= r_c2_t;
      r_c1_m <= r_c2_m;
      r_c1_b <= r_c2_b;
      r_c2_t <= w_lb_top;
      r_c2_m <= w_lb_mid;
      r_c2_b <= w_pix;
    end
  end

  assign w_gx_raw = (K_S * sx(w_lb_top) + K_C * sx(w_lb_mid) + K_S * sx(w_pix))
                  - (K_S * sx(r_c1_t)   + K_C * sx(r_c1_m)   + K_S * sx(r_c1_b));
  assign w_gy_raw = (K_S * sx(r_c1_b)   + K_C * sx(r_c2_b)   + K_S * sx(w_pix))
                  - (K_S * sx(r_c1_t)   + K_C * sx(r_c2_t)   + K_S * sx(w_lb_top));

  // Result register: borders forced to zero, interior clamped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      gx        <= '0;
      gy        <= '0;
    end else begin
      out_valid <= w_emit;
      if (w_emit) begin
        out_addr <= r_res_addr;
        gx <= w_border ? '0 : PIX_W'(clamp_pix(CLAMP_W'(w_gx_raw), PIX_W));
        gy <= w_border ? '0 : PIX_W'(clamp_pix(CLAMP_W'(w_gy_raw), PIX_W));
      end
    end
  end

`ifdef SOBEL_MAG_EN
  function automatic logic signed [RW:0] abs_ext(input logic signed [RW-1:0] v);
    logic signed [RW:0] e;
    e = (RW + 1)'(v);
    return (e < 0) ? -e : e;
  endfunction

  logic signed [RW:0] w_mag_raw;
  assign w_mag_raw = abs_ext(w_gx_raw) + abs_ext(w_gy_raw);

  // Magnitude registered in step with gx/gy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mag <= '0;
    else if (w_emit)
      mag <= w_border ? '0 : PIX_W'(clamp_pix(CLAMP_W'(w_mag_raw), PIX_W));
  end
`else
  // Magnitude path not built.
`endif

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream with a frame-level reference model and scoreboard.
// Latency: checks first-result offset, contiguity of results and done placement.
// Backpressure: not applicable; memory model answers every read one cycle later.
module tb_sobel_stream;

  localparam int W = 8;
  localparam int H = 6;
  localparam int P = 4;
  localparam int A = 10;
  localparam int N = W * H;
  localparam int PMAX = (1 << P) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy, done, rd_en, out_valid;
  logic [A-1:0] rd_addr, out_addr;
  logic [P-1:0] rd_data = '0;
  logic [P-1:0] gx, gy;
`ifdef SOBEL_MAG_EN
  logic [P-1:0] mag;
`endif

  sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(P), .ADDR_W(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .gx        (gx),
`ifdef SOBEL_MAG_EN
    .mag       (mag),
`endif
    .gy        (gy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int addr;
    int gx;
    int gy;
    int mg;
  } res_t;

  int   img     [N];
  int   exp_gx  [N];
  int   exp_gy  [N];
  int   exp_mag [N];
  res_t expq [$];
  res_t mon_e;

  int n_out, rd_exp, first_out_cyc, last_out_cyc, start_cyc;
  bit mem_req = 1'b0;
  int mem_addr = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int clampv(input int v);
    return (v < 0) ? 0 : ((v > PMAX) ? PMAX : v);
  endfunction

  function automatic int px(input int r, input int c);
    return img[r * W + c];
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic set_pattern(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r * W + c] = 9;
          1:       img[r * W + c] = (c < 4) ? 0 : 15;
          2:       img[r * W + c] = (c < 4) ? 15 : 0;
          3:       img[r * W + c] = r;
          default: img[r * W + c] = (r * r + 3 * c + r * c) % 16;
        endcase
  endtask

  // Reference: Sobel over the 2-D image, border results zero.
  task automatic build_model();
    expq.delete();
    for (int p = 0; p < N; p++) begin
      int r, c, lft, rgt, top, bot, gxr, gyr;
      res_t e;
      r = p / W;
      c = p % W;
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
        exp_gx[p] = 0; exp_gy[p] = 0; exp_mag[p] = 0;
      end else begin
        lft = px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1);
        rgt = px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1);
        top = px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1);
        bot = px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1);
        gxr = rgt - lft;
        gyr = bot - top;
        exp_gx[p]  = clampv(gxr);
        exp_gy[p]  = clampv(gyr);
        exp_mag[p] = clampv(iabs(gxr) + iabs(gyr));
      end
      e.addr = p; e.gx = exp_gx[p]; e.gy = exp_gy[p]; e.mg = exp_mag[p];
      expq.push_back(e);
    end
    n_out = 0;
    rd_exp = 0;
    first_out_cyc = -1;
    last_out_cyc = -1;
  endtask

  // Memory model: answers a read strobe one cycle later.
  always @(posedge clk) begin
    #1;
    if (mem_req && mem_addr < N)
      rd_data = P'(img[mem_addr]);
  end

  // Compare process: read sequence and every result against the model.
  always @(negedge clk) begin
    mem_req  = rd_en;
    mem_addr = int'(rd_addr);
    if (!rst) begin
      if (rd_en) begin
        chk("rd_addr", int'(rd_addr), rd_exp);
        rd_exp++;
      end
      if (out_valid) begin
        if (n_out > 0)
          chk("out_contiguous", cyc - last_out_cyc, 1);
        if (first_out_cyc < 0)
          first_out_cyc = cyc;
        last_out_cyc = cyc;
        n_out++;
        if (expq.size() == 0) begin
          chk("extra_result", n_out, N);
        end else begin
          mon_e = expq.pop_front();
          chk("out_addr", int'(out_addr), mon_e.addr);
          chk("gx", int'(gx), mon_e.gx);
          chk("gy", int'(gy), mon_e.gy);
`ifdef SOBEL_MAG_EN
          chk("mag", int'(mag), mon_e.mg);
`endif
        end
      end
    end
  end

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", int'(busy), 1);
    chk("rd_en_after_start", int'(rd_en), 1);
  endtask

  task automatic wait_done(input int pulse_at);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      if (done) begin
        seen = 1'b1;
        chk("done_after_last_out", cyc - last_out_cyc, 1);
        chk("out_valid_low_at_done", int'(out_valid), 0);
        chk("busy_low_at_done", int'(busy), 0);
        break;
      end
    end
    start = 1'b0;
    if (!seen)
      chk("done_timeout", 0, 1);
  endtask

  task automatic check_frame_totals();
    chk("result_count", n_out, N);
    chk("queue_drained", expq.size(), 0);
    // start_cyc is the first cycle after the sampling edge (k+1); first result is at k+W+4.
    chk("first_out_latency", first_out_cyc - start_cyc, W + 3);
  endtask

  task automatic quiet_after(input int ncyc);
    int extra_done, extra_vld;
    extra_done = 0;
    extra_vld = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) extra_done++;
      if (out_valid) extra_vld++;
    end
    chk("no_extra_done", extra_done, 0);
    chk("no_extra_valid", extra_vld, 0);
  endtask

  task automatic run_frame(input int pulse_at);
    build_model();
    launch();
    wait_done(pulse_at);
    check_frame_totals();
    quiet_after(5);
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_addr", int'(out_addr), 0);
    chk("rst_gx", int'(gx), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Constant frame.
    set_pattern(0);
    build_model();
    chk("model_const_gx", exp_gx[2 * W + 3], 0);
    run_frame(-1);

    // Vertical step with a stray start mid-frame.
    set_pattern(1);
    build_model();
    chk("model_vstep_gx_c3", exp_gx[2 * W + 3], 15);
    chk("model_vstep_gx_c4", exp_gx[3 * W + 4], 15);
    chk("model_vstep_gx_c2", exp_gx[2 * W + 2], 0);
    chk("model_vstep_gy_c3", exp_gy[2 * W + 3], 0);
    run_frame(20);

    // Inverted step, chained back-to-back with start held through DONE.
    set_pattern(2);
    build_model();
    chk("model_inv_gx_c3", exp_gx[2 * W + 3], 0);
    chk("model_inv_mag_c3", exp_mag[2 * W + 3], 15);
    chk("model_inv_mag_c5", exp_mag[2 * W + 5], 0);
    launch();
    wait_done(-1);
    check_frame_totals();
    start = 1'b1;
    build_model();
    @(negedge clk);
    chk("idle_after_done_busy", int'(busy), 0);
    chk("idle_after_done_rd_en", int'(rd_en), 0);
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    chk("rearm_busy", int'(busy), 1);
    chk("rearm_rd_en", int'(rd_en), 1);
    wait_done(-1);
    check_frame_totals();
    quiet_after(5);

    // Vertical ramp, aborted by reset at result 20, then rerun.
    set_pattern(3);
    build_model();
    chk("model_ramp_gy", exp_gy[2 * W + 3], 8);
    chk("model_ramp_gx", exp_gx[2 * W + 3], 0);
    launch();
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (out_valid && out_addr == A'(20)) begin
          found = 1'b1;
          break;
        end
      end
      if (!found)
        chk("reach_addr20", 0, 1);
    end
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_rd_en", int'(rd_en), 0);
    chk("abort_rd_addr", int'(rd_addr), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_addr", int'(out_addr), 0);
    chk("abort_gy", int'(gy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet_after(80);
    run_frame(-1);

    // Irregular texture exercises every tap weight and position.
    set_pattern(4);
    run_frame(-1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got time %0t, expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Parametrised, streaming 3×3 Sobel edge engine that replaces the per-pixel random-access kernel in the image memory block. On `start` it reads the frame once in raster order from the frame memory read port. It buffers two lines internally and emits saturated `gx`/`gy` results, one per cycle, in raster order, then pulses `done`. It sits between the frame memory (read side) and the result write-back / display path.

## Interface
- `IMG_W`, 32: image width in pixels, must be ≥ 3.
- `IMG_H`, 32: image height in pixels, must be ≥ 3.
- `PIX_W`, 4: pixel width in bits, taken from the low bits of memory words.
- `ADDR_W`, 10: frame address width; IMG_W*IMG_H ≤ 2^ADDR_W.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse after the last result.
- `rd_en`  out  1  frame memory read strobe.
- `rd_addr`  out  ADDR_W  frame memory read address.
- `rd_data`  in  PIX_W  pixel, valid the cycle after `rd_en`.
- `out_valid`  out  1  result strobe.
- `out_addr`  out  ADDR_W  raster index of the result pixel.
- `gx`  out  PIX_W  horizontal gradient, clamped.
- `gy`  out  PIX_W  vertical gradient, clamped.
- `mag`  out  PIX_W  |gx|+|gy|, clamped; present only with `SOBEL_MAG_EN`.

## Operation
- FSM states: IDLE, READ, FLUSH, DONE.
  - IDLE→READ on `start`.
  - READ→FLUSH after read N-1, where N = IMG_W*IMG_H.
  - FLUSH→DONE when result N-1 is issued.
  - DONE→IDLE unconditionally.
- READ: `rd_en`=1 every cycle; `rd_addr` counts 0..N-1 with no gaps.
- FLUSH: no reads; zeros are shifted into the window for IMG_W+1 cycles so the pipeline drains.
- Window: two IMG_W-deep line buffers plus a 3×3 register window. The window advances one pixel per cycle while pixels arrive or flush.
- The centre (r,c) result becomes computable once pixel (r+1,c+1) has entered the window.
- Border pixels (r=0, r=IMG_H-1, c=0, c=IMG_W-1) output gx=gy=mag=0. Line wrap never mixes columns across rows.
- Interior kernel, with aRC meaning row R, column C of the window:
  - gx = (a13+2·a23+a33) − (a11+2·a21+a31)
  - gy = (a31+2·a32+a33) − (a11+2·a12+a13)
- Arithmetic is signed, PIX_W+4 bits; no overflow is possible.
- Clamp: raw < 0 → 0; raw > 2^PIX_W−1 → 2^PIX_W−1; otherwise raw[PIX_W-1:0].
- `start` while busy is ignored. A `start` high in the DONE cycle is ignored; in IDLE it starts a new frame.
- Reset values, effective immediately: every output is 0, FSM in IDLE, counters 0. Line buffers need no reset.
- Reset mid-frame abandons the frame; no `done` is issued.

## Timing
- `start` sampled high at edge k: `busy`=1 and the first `rd_en`/`rd_addr`=0 appear in cycle k+1.
- Result latency: `out_valid` for pixel p is 2 cycles after the `rd_en` cycle of pixel p+IMG_W+1, or after the equivalent flush slot.
- The first `out_valid` is in cycle k+IMG_W+4.
- `out_valid` is then high for exactly N consecutive cycles; `out_addr` runs 0..N-1.
- `done` is high for one cycle immediately after the last `out_valid`. `busy` drops in the same cycle as `done`.
- Throughput: 1 pixel/cycle.
- Frame period: N+IMG_W+5 cycles including the IDLE re-arm.

## Configuration
- `SOBEL_MAG_EN` defined: the `mag` port exists. It is registered alongside `gx`/`gy` with identical latency: |raw_gx|+|raw_gy| on PIX_W+5 bits, clamped to 2^PIX_W−1.
- `SOBEL_MAG_EN` undefined: the `mag` port and its logic are absent; all other behaviour is unchanged.

## Structure
- Package `sobel_pkg` holds:
  - the FSM state enum (`sobel_state_t`);
  - the `clamp_pix` function (signed raw → PIX_W);
  - the kernel-weight localparams.
- Sub-module `sobel_linebuf`: a single-port-per-cycle, IMG_W-deep, PIX_W-wide delay line. It is instantiated twice to form rows r−1 and r.
- Top module contains the FSM, read/result counters, window registers, kernel arithmetic and clamping.

## Test plan
- Bench parameters are IMG_W=8, IMG_H=6, PIX_W=4.
- Constant frame, all pixels 9 → 48 results, all gx=gy=0. `done` appears one cycle after `out_addr`=47. The first `out_valid` is 12 cycles after the `start` edge.
- Vertical step, columns 0–3 = 0 and columns 4–7 = 15 → interior columns 3 and 4 give gx=15 (raw 60, saturated) and gy=0. Columns 1, 2, 5, 6 give 0. Border columns give 0.
- Vertical step inverted, columns 0–3 = 15 and columns 4–7 = 0 → raw gx = −60 is clamped, so every result is 0. With `SOBEL_MAG_EN`, mag=15 at columns 3 and 4.
- Horizontal ramp, row r = r, 1 pixel per row → interior gy = 8, clamped value 8. gx=0.
- `start` pulsed again mid-frame → ignored: exactly 48 results and one `done`. Back-to-back `start` in IDLE right after `done` → second frame identical.
- `rst` asserted at `out_addr`=20 → all outputs 0 asynchronously and no `done`. A fresh `start` then yields a full correct frame.
